toggle_event_rx: RTL and testbench

Receive end of a toggle-encoded event link. A transmitter toggle flip-flop flips its output once per event. This block samples that level asynchronously, recovers one event per level change, and counts the events. It also buffers pending events behind a valid/ready handshake for a slower consumer. It sits at clock-domain boundaries between the toggle-FF sender and local control logic.

---
 rtl/toggle_link_pkg.sv | 14 +
 rtl/toggle_event_rx_if.sv | 23 ++
 rtl/sync_chain.sv | 22 ++
 rtl/toggle_event_rx.sv | 98 +++++++++
 tb/tb_toggle_event_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/toggle_link_pkg.sv
// Shared types and default sizing for the toggle-encoded event link.
// Receive FSM: ARM masks edges while the synchronizer settles, RUN detects them.
package toggle_link_pkg;

    typedef enum logic [0:0] {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;
    localparam int PEND_W_DEF      = 4;

endpackage

// File: rtl/toggle_event_rx_if.sv
// Event-side bundle of the toggle receiver: pulse, pending-event handshake and counters.
// master = receiver (drives events, samples evt_ready), slave = consumer.
interface toggle_event_rx_if import toggle_link_pkg::*; #(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PEND_W = PEND_W_DEF
);
    logic              evt_pulse;
    logic              evt_valid;
    logic              evt_ready;
    logic [PEND_W-1:0] pend_cnt;
    logic [CNT_W-1:0]  total_cnt;
    logic              overflow;

    modport master (
        output evt_pulse, evt_valid, pend_cnt, total_cnt, overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_pulse, evt_valid, pend_cnt, total_cnt, overflow,
        output evt_ready
    );
endinterface

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous level; latency N cycles, no backpressure.
// Synchronous active-high clear zeroes every stage.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], d};
        end
    end

    assign q = r_sync[N-1];
endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-link receiver: one event per synchronized level change, pulse after SYNC_STAGES+1 cycles.
// Events queue in a saturating pending counter drained one per cycle by evt_valid/evt_ready.
module toggle_event_rx import toggle_link_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PEND_W      = PEND_W_DEF
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      tog_in,
    output logic                      tog_level,
    output logic                      armed,
    toggle_event_rx_if.master         evt
);
    localparam int                ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            r_state;
    logic [ARM_W-1:0]  r_arm_cnt;
    logic              r_prev;
    logic              r_pulse;
    logic              r_armed;
    logic              r_ovf;
    logic [PEND_W-1:0] r_pend;
    logic [CNT_W-1:0]  r_total;

    logic w_level;
    logic w_edge;
    logic w_valid;
    logic w_acc;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .clr (clr),
        .d   (tog_in),
        .q   (w_level)
    );

    // prev tracks the level during ARM too, so a level already present at release is absorbed
    assign w_edge  = (r_state == ST_RUN) && (w_level ^ r_prev);
    assign w_valid = (r_pend != '0);
    assign w_acc   = w_valid && evt.evt_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
            r_prev    <= 1'b0;
            r_pulse   <= 1'b0;
            r_armed   <= 1'b0;
            r_ovf     <= 1'b0;
            r_pend    <= '0;
            r_total   <= '0;
        end else begin
            r_prev  <= w_level;
            r_pulse <= w_edge;

            case (r_state)
                ST_ARM: begin
                    if (r_arm_cnt == ARM_LAST) begin
                        r_state   <= ST_RUN;
                        r_armed   <= 1'b1;
                        r_arm_cnt <= '0;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            if (w_edge) begin
                r_total <= r_total + CNT_W'(1);
            end

            // an edge with a simultaneous accept leaves the count untouched, even when full
            if (w_edge && !w_acc) begin
                if (r_pend == PEND_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend <= r_pend + PEND_W'(1);
                end
            end else if (w_acc && !w_edge) begin
                r_pend <= r_pend - PEND_W'(1);
            end
        end
    end

    assign tog_level     = w_level;
    assign armed         = r_armed;
    assign evt.evt_pulse = r_pulse;
    assign evt.evt_valid = w_valid;
    assign evt.pend_cnt  = r_pend;
    assign evt.total_cnt = r_total;
    assign evt.overflow  = r_ovf;
endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed bench for toggle_event_rx: arming, latency, saturation, wrap and clear.
`timescale 1ns/1ps
module tb_toggle_event_rx;
    logic clk;
    logic clr;
    logic tog_in;
    logic tog_level;
    logic armed;

    int n_cmp;
    int n_err;
    int n_pulse;
    int n_bad;
    logic p1;
    logic p2;

    toggle_event_rx_if #(.CNT_W(8), .PEND_W(4)) evt_if ();

    toggle_event_rx #(.SYNC_STAGES(2), .CNT_W(8), .PEND_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .tog_in    (tog_in),
        .tog_level (tog_level),
        .armed     (armed),
        .evt       (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr = 1'b1;
        tog_in = 1'b1;
        evt_if.evt_ready = 1'b0;
        repeat (3) tick();

        check_val("rst_armed", 32'(armed), 0);
        check_val("rst_level", 32'(tog_level), 0);
        check_val("rst_pulse", 32'(evt_if.evt_pulse), 0);
        check_val("rst_total", 32'(evt_if.total_cnt), 0);
        check_val("rst_pend", 32'(evt_if.pend_cnt), 0);
        check_val("rst_valid", 32'(evt_if.evt_valid), 0);
        check_val("rst_ovf", 32'(evt_if.overflow), 0);

        // release with tog_in held high: armed after 3 edges, nothing counted
        clr = 1'b0;
        tick();
        tick();
        check_val("arm_early", 32'(armed), 0);
        tick();
        check_val("arm_rise", 32'(armed), 1);
        n_pulse = 0;
        repeat (4) begin
            tick();
            if (evt_if.evt_pulse) n_pulse++;
        end
        check_val("arm_nopulse", 32'(n_pulse), 0);
        check_val("arm_total", 32'(evt_if.total_cnt), 0);
        check_val("arm_pend", 32'(evt_if.pend_cnt), 0);

        // single toggle: pulse on the 3rd edge, one cycle wide
        tog_in = 1'b0;
        tick();
        p1 = evt_if.evt_pulse;
        tick();
        p2 = evt_if.evt_pulse;
        check_val("lat_early", 32'({p1, p2}), 0);
        tick();
        check_val("lat_pulse", 32'(evt_if.evt_pulse), 1);
        check_val("one_total", 32'(evt_if.total_cnt), 1);
        check_val("one_pend", 32'(evt_if.pend_cnt), 1);
        check_val("one_valid", 32'(evt_if.evt_valid), 1);
        tick();
        check_val("pulse_width", 32'(evt_if.evt_pulse), 0);
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        check_val("acc_pend", 32'(evt_if.pend_cnt), 0);
        check_val("acc_valid", 32'(evt_if.evt_valid), 0);

        // 20 back-to-back toggles, consumer stalled
        n_pulse = 0;
        for (int i = 0; i < 25; i++) begin
            if (i < 20) tog_in = ~tog_in;
            tick();
            if (evt_if.evt_pulse) begin
                n_pulse++;
                if (n_pulse == 15) begin
                    check_val("fill15_pend", 32'(evt_if.pend_cnt), 15);
                    check_val("fill15_ovf", 32'(evt_if.overflow), 0);
                end
                if (n_pulse == 16) begin
                    check_val("fill16_pend", 32'(evt_if.pend_cnt), 15);
                    check_val("fill16_ovf", 32'(evt_if.overflow), 1);
                end
            end
        end
        check_val("burst_pulses", 32'(n_pulse), 20);
        check_val("burst_total", 32'(evt_if.total_cnt), 21);
        check_val("burst_pend", 32'(evt_if.pend_cnt), 15);
        check_val("burst_ovf", 32'(evt_if.overflow), 1);

        // drain 8 so pend=7 with overflow still set
        evt_if.evt_ready = 1'b1;
        repeat (8) tick();
        evt_if.evt_ready = 1'b0;
        check_val("drain_pend", 32'(evt_if.pend_cnt), 7);
        check_val("drain_ovf", 32'(evt_if.overflow), 1);

        // one-cycle clear, then a toggle inside the ARM window
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tog_in = 1'b1;
        check_val("clr_armed", 32'(armed), 0);
        check_val("clr_pend", 32'(evt_if.pend_cnt), 0);
        check_val("clr_total", 32'(evt_if.total_cnt), 0);
        check_val("clr_ovf", 32'(evt_if.overflow), 0);
        check_val("clr_pulse", 32'(evt_if.evt_pulse), 0);
        check_val("clr_level", 32'(tog_level), 0);
        check_val("clr_valid", 32'(evt_if.evt_valid), 0);
        n_pulse = 0;
        repeat (6) begin
            tick();
            if (evt_if.evt_pulse) n_pulse++;
        end
        check_val("armtog_pulses", 32'(n_pulse), 0);
        check_val("armtog_total", 32'(evt_if.total_cnt), 0);
        check_val("armtog_armed", 32'(armed), 1);

        // fill to exactly 15, then edge + accept together while full
        for (int i = 0; i < 15; i++) begin
            tog_in = ~tog_in;
            tick();
        end
        repeat (3) tick();
        check_val("full_pend", 32'(evt_if.pend_cnt), 15);
        check_val("full_ovf", 32'(evt_if.overflow), 0);
        check_val("full_total", 32'(evt_if.total_cnt), 15);
        tog_in = ~tog_in;
        tick();
        tick();
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        check_val("simul_pulse", 32'(evt_if.evt_pulse), 1);
        check_val("simul_pend", 32'(evt_if.pend_cnt), 15);
        check_val("simul_ovf", 32'(evt_if.overflow), 0);
        check_val("simul_total", 32'(evt_if.total_cnt), 16);

        // drain, then stream with ready held: pend sits at 1 on every pulse
        evt_if.evt_ready = 1'b1;
        repeat (15) tick();
        check_val("empty_pend", 32'(evt_if.pend_cnt), 0);
        n_pulse = 0;
        n_bad = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) tog_in = ~tog_in;
            tick();
            if (evt_if.evt_pulse) begin
                n_pulse++;
                if (evt_if.pend_cnt != 4'd1) n_bad++;
            end
        end
        check_val("stream_pulses", 32'(n_pulse), 10);
        check_val("stream_pend1", 32'(n_bad), 0);
        check_val("stream_end_pend", 32'(evt_if.pend_cnt), 0);
        check_val("stream_total", 32'(evt_if.total_cnt), 26);

        // 260 events from a fresh clear: counter wraps to 4
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        check_val("wrap_armed", 32'(armed), 1);
        n_pulse = 0;
        for (int i = 0; i < 265; i++) begin
            if (i < 260) tog_in = ~tog_in;
            tick();
            if (evt_if.evt_pulse) n_pulse++;
        end
        evt_if.evt_ready = 1'b0;
        check_val("wrap_pulses", 32'(n_pulse), 260);
        check_val("wrap_total", 32'(evt_if.total_cnt), 4);
        check_val("wrap_ovf", 32'(evt_if.overflow), 0);
        check_val("wrap_pend", 32'(evt_if.pend_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
